// File: rtl/axi4_fill_ctrl.sv
// ---------------------------------------------------------------------------
// axi4_fill_ctrl
//
// AXI4 write-master sequencer that fills a memory region with a data pattern.
// A start/base/length command is split into INCR bursts. No burst is longer
// than MAX_BURST beats, and no burst crosses a 4KB page. Only one
// transaction is in flight at a time: AW completes, then all W beats, then B.
// Bursts that come back with a non-OKAY response are counted in err_cnt.
//
// Ports
//   ACLK, ARESETn   clock, asynchronous active-low reset
//   start           command strobe; only sampled while IDLE
//   base_addr       start byte address (bits [1:0] ignored)
//   num_words       number of words to write (0 = immediate done)
//   seed, mode      pattern: mode 0 -> seed, mode 1 -> seed + word index
//   busy, done      busy while a command runs; done is a one-cycle pulse
//   err_cnt         saturating count of error responses for this command
//   AW*/W*/B*       AXI4 write-channel master signals
//
// State table
//   IDLE | wait for start
//   CALC | size the next burst (length, 4KB limit, MAX_BURST limit)
//   AW   | present burst address, wait for AWREADY
//   W    | stream the burst's data beats
//   B    | wait for the write response, advance address and remaining count
//   DONE | one-cycle completion pulse
// ---------------------------------------------------------------------------
module axi4_fill_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_BURST  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]           num_words,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic                  mode,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            err_cnt,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WVALID,
  output logic                  WLAST,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CALC = 3'd1;
  localparam logic [2:0] ST_AW   = 3'd2;
  localparam logic [2:0] ST_W    = 3'd3;
  localparam logic [2:0] ST_B    = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [15:0]           remaining;
  logic [15:0]           word_idx;
  logic [DATA_WIDTH-1:0] seed_q;
  logic                  mode_q;
  logic [8:0]            beats;
  logic [7:0]            beat_cnt;

  logic [12:0]           page_room;
  logic [8:0]            beats_calc;
  logic [DATA_WIDTH-1:0] word_cur;
  logic [DATA_WIDTH-1:0] word_nxt;

  assign AWSIZE = 3'b010;

  // Words left before the next 4KB boundary; 1..1024 for an aligned address.
  assign page_room = (13'd4096 - {1'b0, cur_addr[11:0]}) >> 2;

  always_comb begin
    beats_calc = 9'(MAX_BURST);
    if ({3'b000, page_room} < {7'b0, beats_calc})
      beats_calc = page_room[8:0];
    if (remaining < {7'b0, beats_calc})
      beats_calc = remaining[8:0];
  end

  // Pattern for the current word index and for the one after it; the second
  // is what gets loaded when a non-last beat handshakes.
  assign word_cur = mode_q ? (seed_q + DATA_WIDTH'(word_idx)) : seed_q;
  assign word_nxt = mode_q ? (seed_q + DATA_WIDTH'(word_idx + 16'd1)) : seed_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= ST_IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      word_idx  <= '0;
      seed_q    <= '0;
      mode_q    <= 1'b0;
      beats     <= '0;
      beat_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_cnt   <= '0;
      AWADDR    <= '0;
      AWLEN     <= '0;
      AWVALID   <= 1'b0;
      WDATA     <= '0;
      WVALID    <= 1'b0;
      WLAST     <= 1'b0;
      BREADY    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            err_cnt <= '0;
            if (num_words != 16'd0) begin
              cur_addr  <= base_addr & WORD_MASK;
              remaining <= num_words;
              seed_q    <= seed;
              mode_q    <= mode;
              word_idx  <= '0;
              busy      <= 1'b1;
              state     <= ST_CALC;
            end else begin
              // Empty command: acknowledge without touching the bus.
              done <= 1'b1;
            end
          end
        end

        ST_CALC: begin
          beats   <= beats_calc;
          AWADDR  <= cur_addr;
          // A 256-beat burst wraps to 8'hFF here, which is the right AWLEN.
          AWLEN   <= beats_calc[7:0] - 8'd1;
          AWVALID <= 1'b1;
          state   <= ST_AW;
        end

        ST_AW: begin
          if (AWREADY) begin
            AWVALID  <= 1'b0;
            WVALID   <= 1'b1;
            WDATA    <= word_cur;
            WLAST    <= (AWLEN == 8'd0);
            beat_cnt <= '0;
            state    <= ST_W;
          end
        end

        ST_W: begin
          if (WREADY) begin
            word_idx <= word_idx + 16'd1;
            beat_cnt <= beat_cnt + 8'd1;
            if (WLAST) begin
              WVALID <= 1'b0;
              WLAST  <= 1'b0;
              BREADY <= 1'b1;
              state  <= ST_B;
            end else begin
              WDATA <= word_nxt;
              WLAST <= ((beat_cnt + 8'd1) == AWLEN);
            end
          end
        end

        ST_B: begin
          if (BVALID) begin
            BREADY <= 1'b0;
            if (BRESP != 2'b00 && err_cnt != 8'hFF)
              err_cnt <= err_cnt + 8'd1;
            cur_addr  <= cur_addr + ADDR_WIDTH'({beats, 2'b00});
            remaining <= remaining - {7'b0, beats};
            if (remaining == {7'b0, beats}) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_DONE;
            end else begin
              state <= ST_CALC;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_fill_ctrl.sv
module tb_axi4_fill_ctrl;

  logic        ACLK;
  logic        ARESETn;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] num_words;
  logic [31:0] seed;
  logic        mode;
  logic        busy;
  logic        done;
  logic [7:0]  err_cnt;
  logic [15:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic        WVALID;
  logic        WLAST;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;

  axi4_fill_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MAX_BURST(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .start(start), .base_addr(base_addr),
    .num_words(num_words), .seed(seed), .mode(mode), .busy(busy), .done(done),
    .err_cnt(err_cnt), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .WDATA(WDATA), .WVALID(WVALID),
    .WLAST(WLAST), .WREADY(WREADY), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int checks = 0;
  int failures = 0;

  typedef struct packed { logic [15:0] addr; logic [7:0] len; } aw_t;
  typedef struct packed { logic [31:0] data; logic last; } w_t;
  aw_t exp_aw[$];
  w_t  exp_w[$];

  // slave model configuration and state
  logic [31:0] mem [0:16383];
  int   mem_depth = 16384;
  int   aw_delay = 0;
  int   b_delay = 0;
  bit   w_toggle = 0;
  bit   aw_open, b_pending, b_err, w_phase;
  bit   prev_aw_stall, prev_w_stall, prev_b_fire;
  bit   aw_fire, w_fire, b_fire;
  int   aw_wait, b_wait, beat, word;
  int   stall_checks = 0;
  logic [15:0] cur_aw_addr, st_awaddr;
  logic [7:0]  st_awlen;
  logic [31:0] st_wdata;
  logic        st_wlast;
  aw_t  ea;
  w_t   ew;

  // AXI slave + scoreboard consumer, all activity on the falling edge
  initial begin
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 2'b00;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 2'b00;
        aw_open = 0; b_pending = 0; b_err = 0; w_phase = 1;
        aw_wait = 0; b_wait = 0; beat = 0;
        prev_aw_stall = 0; prev_w_stall = 0; prev_b_fire = 0;
      end else begin
        if (done === 1'b1) begin
          checks++;
          if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_at_done: busy=%b required 0", busy);
          end
        end
        if (prev_aw_stall) begin
          checks++; stall_checks++;
          if (AWVALID !== 1'b1 || AWADDR !== st_awaddr || AWLEN !== st_awlen) begin
            failures++;
            $display("FAIL aw_stable: AWVALID=%b AWADDR=%h AWLEN=%0d required 1 %h %0d",
                     AWVALID, AWADDR, AWLEN, st_awaddr, st_awlen);
          end
        end
        if (prev_w_stall) begin
          checks++; stall_checks++;
          if (WVALID !== 1'b1 || WDATA !== st_wdata || WLAST !== st_wlast) begin
            failures++;
            $display("FAIL w_stable: WVALID=%b WDATA=%h WLAST=%b required 1 %h %b",
                     WVALID, WDATA, WLAST, st_wdata, st_wlast);
          end
        end
        if (prev_b_fire) begin
          BVALID = 0; b_pending = 0;
        end

        if (AWVALID === 1'b1) begin
          AWREADY = (aw_wait >= aw_delay);
          if (!AWREADY) aw_wait++;
        end else AWREADY = 0;
        if (WVALID === 1'b1) begin
          WREADY = w_toggle ? w_phase : 1'b1;
          w_phase = !w_phase;
        end else WREADY = 0;
        if (b_pending && !BVALID) begin
          if (b_wait >= b_delay) begin
            BVALID = 1; BRESP = b_err ? 2'b10 : 2'b00;
          end else b_wait++;
        end

        if (WVALID === 1'b1) begin
          checks++;
          if (!aw_open) begin
            failures++;
            $display("FAIL w_before_aw: WVALID=1 with no accepted address");
          end
        end

        aw_fire = (AWVALID === 1'b1) && AWREADY;
        w_fire  = (WVALID === 1'b1) && WREADY;
        b_fire  = BVALID && (BREADY === 1'b1);

        if (aw_fire) begin
          checks++;
          if (exp_aw.size() == 0) begin
            failures++;
            $display("FAIL aw_unexpected: AWADDR=%h AWLEN=%0d required none", AWADDR, AWLEN);
          end else begin
            ea = exp_aw.pop_front();
            if (AWADDR !== ea.addr || AWLEN !== ea.len || AWSIZE !== 3'b010 || aw_open || b_pending) begin
              failures++;
              $display("FAIL aw_burst: AWADDR=%h AWLEN=%0d AWSIZE=%b outstanding=%b required %h %0d 010 0",
                       AWADDR, AWLEN, AWSIZE, aw_open | b_pending, ea.addr, ea.len);
            end
          end
          aw_open = 1; cur_aw_addr = AWADDR; beat = 0; b_err = 0; aw_wait = 0;
        end
        if (w_fire) begin
          checks++;
          if (exp_w.size() == 0) begin
            failures++;
            $display("FAIL w_unexpected: WDATA=%h required none", WDATA);
          end else begin
            ew = exp_w.pop_front();
            if (WDATA !== ew.data || WLAST !== ew.last) begin
              failures++;
              $display("FAIL w_beat: WDATA=%h WLAST=%b required %h %b", WDATA, WLAST, ew.data, ew.last);
            end
          end
          word = int'(cur_aw_addr >> 2) + beat;
          if (word < mem_depth && word < 16384) mem[word] = WDATA;
          else b_err = 1;
          beat++;
          if (WLAST === 1'b1) begin
            aw_open = 0; b_pending = 1; b_wait = 0;
          end
        end

        prev_aw_stall = (AWVALID === 1'b1) && !AWREADY;
        st_awaddr = AWADDR; st_awlen = AWLEN;
        prev_w_stall = (WVALID === 1'b1) && !WREADY;
        st_wdata = WDATA; st_wlast = WLAST;
        prev_b_fire = b_fire;
      end
    end
  end

  // Independent burst-splitting model feeding the scoreboard.
  task automatic push_cmd(input int base, input int n, input logic [31:0] sd, input logic md);
    int addr, rem, idx, room, b;
    aw_t a;
    w_t  w;
    addr = base & 32'hFFFC; rem = n; idx = 0;
    while (rem > 0) begin
      room = (4096 - (addr % 4096)) / 4;
      b = rem;
      if (b > 16) b = 16;
      if (b > room) b = room;
      a.addr = 16'(addr); a.len = 8'(b - 1);
      exp_aw.push_back(a);
      for (int k = 0; k < b; k++) begin
        w.data = md ? (sd + 32'(idx)) : sd;
        w.last = (k == b - 1);
        exp_w.push_back(w);
        idx++;
      end
      addr = (addr + b * 4) % 65536;
      rem -= b;
    end
  endtask

  task automatic drive_cmd(input int base, input int n, input logic [31:0] sd, input logic md,
                           output int aw_lat, output int done_lat, output int pulses);
    push_cmd(base, n, sd, md);
    @(negedge ACLK);
    base_addr = 16'(base); num_words = 16'(n); seed = sd; mode = md; start = 1;
    aw_lat = -1; done_lat = -1; pulses = 0;
    for (int k = 1; k <= 4000; k++) begin
      @(negedge ACLK);
      if (k == 1) start = 0;
      if (AWVALID === 1'b1 && aw_lat < 0) aw_lat = k;
      if (done === 1'b1) begin
        pulses++;
        if (done_lat < 0) done_lat = k;
      end
      if (done_lat >= 0 && k >= done_lat + 3) break;
    end
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 16384; k++) mem[k] = 32'hDEAD_BEEF;
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 0 || done !== 0 || err_cnt !== 0) begin
      failures++;
      $display("FAIL reset_status: busy=%b done=%b err_cnt=%0d required 0 0 0", busy, done, err_cnt);
    end
    checks++;
    if (AWADDR !== 0 || AWLEN !== 0 || AWVALID !== 0 || AWSIZE !== 3'b010) begin
      failures++;
      $display("FAIL reset_aw: AWADDR=%h AWLEN=%0d AWVALID=%b AWSIZE=%b required 0 0 0 010",
               AWADDR, AWLEN, AWVALID, AWSIZE);
    end
    checks++;
    if (WDATA !== 0 || WVALID !== 0 || WLAST !== 0 || BREADY !== 0) begin
      failures++;
      $display("FAIL reset_wb: WDATA=%h WVALID=%b WLAST=%b BREADY=%b required 0 0 0 0",
               WDATA, WVALID, WLAST, BREADY);
    end
  endtask

  task automatic test_single_burst();
    int al, dl, p;
    clear_mem();
    drive_cmd(16'h0000, 4, 32'h100, 1'b1, al, dl, p);
    checks++;
    if (dl < 0 || p !== 1) begin
      failures++;
      $display("FAIL single_done: pulses=%0d required 1", p);
    end
    checks++;
    if (al !== 2) begin
      failures++;
      $display("FAIL single_aw_latency: got %0d cycles required 2", al);
    end
    checks++;
    if (err_cnt !== 0 || busy !== 0) begin
      failures++;
      $display("FAIL single_status: err_cnt=%0d busy=%b required 0 0", err_cnt, busy);
    end
    checks++;
    if (exp_aw.size() != 0 || exp_w.size() != 0) begin
      failures++;
      $display("FAIL single_drain: aw_left=%0d w_left=%0d required 0 0", exp_aw.size(), exp_w.size());
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem[k] !== 32'h100 + 32'(k)) begin
        failures++;
        $display("FAIL single_mem[%0d]: got %h required %h", k, mem[k], 32'h100 + 32'(k));
      end
    end
  endtask

  task automatic test_multi_burst();
    int al, dl, p;
    clear_mem();
    drive_cmd(16'h0000, 40, 32'h1000_0000, 1'b1, al, dl, p);
    checks++;
    if (dl < 0 || p !== 1) begin
      failures++;
      $display("FAIL multi_done: pulses=%0d required 1", p);
    end
    checks++;
    if (exp_aw.size() != 0 || exp_w.size() != 0) begin
      failures++;
      $display("FAIL multi_drain: aw_left=%0d w_left=%0d required 0 0", exp_aw.size(), exp_w.size());
    end
    for (int k = 0; k < 40; k++) begin
      checks++;
      if (mem[k] !== 32'h1000_0000 + 32'(k)) begin
        failures++;
        $display("FAIL multi_mem[%0d]: got %h required %h", k, mem[k], 32'h1000_0000 + 32'(k));
      end
    end
  endtask

  task automatic test_4k_split();
    int al, dl, p;
    clear_mem();
    // seed near the top also exercises the pattern wrap
    drive_cmd(16'h0FF8, 4, 32'hFFFF_FFFE, 1'b1, al, dl, p);
    checks++;
    if (dl < 0 || p !== 1 || err_cnt !== 0) begin
      failures++;
      $display("FAIL split_done: pulses=%0d err_cnt=%0d required 1 0", p, err_cnt);
    end
    checks++;
    if (exp_aw.size() != 0 || exp_w.size() != 0) begin
      failures++;
      $display("FAIL split_drain: aw_left=%0d w_left=%0d required 0 0", exp_aw.size(), exp_w.size());
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem[16'h3FE + k] !== 32'hFFFF_FFFE + 32'(k)) begin
        failures++;
        $display("FAIL split_mem[%0d]: got %h required %h", k, mem[16'h3FE + k], 32'hFFFF_FFFE + 32'(k));
      end
    end
  endtask

  task automatic test_slverr();
    int al, dl, p;
    clear_mem();
    mem_depth = 1024;
    drive_cmd(16'h0FF8, 4, 32'h0000_0055, 1'b1, al, dl, p);
    mem_depth = 16384;
    checks++;
    if (dl < 0 || p !== 1) begin
      failures++;
      $display("FAIL slverr_done: pulses=%0d required 1", p);
    end
    checks++;
    if (err_cnt !== 8'd1) begin
      failures++;
      $display("FAIL slverr_count: err_cnt=%0d required 1", err_cnt);
    end
    checks++;
    if (exp_aw.size() != 0 || exp_w.size() != 0) begin
      failures++;
      $display("FAIL slverr_drain: aw_left=%0d w_left=%0d required 0 0", exp_aw.size(), exp_w.size());
    end
  endtask

  task automatic test_zero_len();
    int al, dl, p;
    drive_cmd(16'h0100, 0, 32'h1234_5678, 1'b0, al, dl, p);
    checks++;
    if (dl !== 1 || p !== 1) begin
      failures++;
      $display("FAIL zero_done: latency=%0d pulses=%0d required 1 1", dl, p);
    end
    checks++;
    if (al !== -1) begin
      failures++;
      $display("FAIL zero_no_aw: AWVALID seen at cycle %0d required never", al);
    end
    checks++;
    if (err_cnt !== 0 || busy !== 0) begin
      failures++;
      $display("FAIL zero_status: err_cnt=%0d busy=%b required 0 0", err_cnt, busy);
    end
  endtask

  task automatic test_backpressure();
    int al, dl, p, sc0;
    clear_mem();
    aw_delay = 3; w_toggle = 1; b_delay = 5;
    sc0 = stall_checks;
    drive_cmd(16'h0FE0, 20, 32'h5A5A_5A5A, 1'b0, al, dl, p);
    aw_delay = 0; w_toggle = 0; b_delay = 0;
    checks++;
    if (dl < 0 || p !== 1 || err_cnt !== 0) begin
      failures++;
      $display("FAIL bp_done: pulses=%0d err_cnt=%0d required 1 0", p, err_cnt);
    end
    checks++;
    if (stall_checks - sc0 < 10) begin
      failures++;
      $display("FAIL bp_stalls: stalled cycles observed=%0d required at least 10", stall_checks - sc0);
    end
    checks++;
    if (exp_aw.size() != 0 || exp_w.size() != 0) begin
      failures++;
      $display("FAIL bp_drain: aw_left=%0d w_left=%0d required 0 0", exp_aw.size(), exp_w.size());
    end
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (mem[16'h3F8 + k] !== 32'h5A5A_5A5A) begin
        failures++;
        $display("FAIL bp_mem[%0d]: got %h required 5a5a5a5a", k, mem[16'h3F8 + k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int al, dl, p, n;
    bit seen;
    push_cmd(16'h0000, 40, 32'h0, 1'b1);
    @(negedge ACLK);
    base_addr = 16'h0000; num_words = 16'd40; seed = 32'h0; mode = 1'b1; start = 1;
    @(negedge ACLK);
    start = 0;
    seen = 0;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge ACLK);
      if (WVALID === 1'b1) n++;
      if (n == 3) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL mid_reach_w: WVALID not seen within 100 cycles");
    end
    ARESETn = 0;
    #1;
    checks++;
    if (busy !== 0 || done !== 0 || err_cnt !== 0 || AWVALID !== 0 || AWADDR !== 0 ||
        AWLEN !== 0 || AWSIZE !== 3'b010 || WVALID !== 0 || WDATA !== 0 || WLAST !== 0 || BREADY !== 0) begin
      failures++;
      $display("FAIL mid_reset_outputs: busy=%b done=%b AWVALID=%b WVALID=%b WDATA=%h BREADY=%b required all 0",
               busy, done, AWVALID, WVALID, WDATA, BREADY);
    end
    p = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      if (done === 1'b1) p++;
    end
    ARESETn = 1;
    exp_aw.delete();
    exp_w.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      if (done === 1'b1) p++;
    end
    checks++;
    if (p !== 0) begin
      failures++;
      $display("FAIL mid_no_done: done pulses=%0d required 0", p);
    end
    clear_mem();
    drive_cmd(16'h0200, 8, 32'h77, 1'b1, al, dl, p);
    checks++;
    if (dl < 0 || p !== 1 || err_cnt !== 0) begin
      failures++;
      $display("FAIL mid_restart: pulses=%0d err_cnt=%0d required 1 0", p, err_cnt);
    end
    checks++;
    if (exp_aw.size() != 0 || exp_w.size() != 0) begin
      failures++;
      $display("FAIL mid_drain: aw_left=%0d w_left=%0d required 0 0", exp_aw.size(), exp_w.size());
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (mem[16'h80 + k] !== 32'h77 + 32'(k)) begin
        failures++;
        $display("FAIL mid_mem[%0d]: got %h required %h", k, mem[16'h80 + k], 32'h77 + 32'(k));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 0; base_addr = 0; num_words = 0; seed = 0; mode = 0;
    ARESETn = 1;
    #2 ARESETn = 0;
    repeat (3) @(negedge ACLK);
    test_reset();
    ARESETn = 1;
    repeat (2) @(negedge ACLK);
    test_reset();
    test_single_burst();
    test_multi_burst();
    test_4k_split();
    test_slverr();
    test_zero_len();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4_fill_ctrl.md
Name: axi4_fill_ctrl

Overview:
AXI4 write-master sequencer that fills a region of the memory-mapped slave with a data pattern. Used for memory initialisation and BIST-style fill ahead of readback checks. Takes a start/base/length command and splits it into INCR bursts that never exceed MAX_BURST beats and never cross a 4KB boundary. Drives the slave's AW/W/B channels and counts bursts that return error responses.

Parameters:
DATA_WIDTH, 32, data bus width; also the word size (4 bytes at the default).
ADDR_WIDTH, 16, byte address width.
MAX_BURST, 16, maximum beats per burst (legal range 1..256).

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
start  in  1  command strobe; sampled only in IDLE
base_addr  in  ADDR_WIDTH  start byte address; bits [1:0] forced to 0
num_words  in  16  number of words to write
seed  in  DATA_WIDTH  pattern seed
mode  in  1  pattern select: 0 = constant seed, 1 = seed+i
busy  out  1  high from start acceptance until done
done  out  1  one-cycle completion pulse
err_cnt  out  8  count of bursts with BRESP!=OKAY; saturates at 255
AWADDR  out  ADDR_WIDTH  burst start address
AWLEN  out  8  beats-1
AWSIZE  out  3  constant 3'b010
AWVALID  out  1  address valid
AWREADY  in  1  address ready
WDATA  out  DATA_WIDTH  write data
WVALID  out  1  data valid
WLAST  out  1  last beat of burst
WREADY  in  1  data ready
BRESP  in  2  write response
BVALID  in  1  response valid
BREADY  out  1  response ready

Behaviour:
- Reset: every output is 0 except AWSIZE, which holds 3'b010; internal counters are 0 and the state is IDLE.
- Reset mid-operation: the transfer aborts immediately, outputs return to reset values, and no done pulse is issued.
- States: IDLE, CALC, AW, W, B, DONE.
- IDLE, start with num_words!=0:
  - latch cur_addr = {base_addr[ADDR_WIDTH-1:2],2'b00}, remaining = num_words, seed and mode; clear word index i and err_cnt.
  - set busy=1 and go to CALC.
- IDLE, start with num_words==0: err_cnt cleared, done pulses on the next cycle, no AXI activity, stay IDLE.
- start while busy: ignored.
- CALC (1 cycle):
  - beats = min(remaining, MAX_BURST, (4096 - cur_addr[11:0])>>2).
  - register AWADDR = cur_addr, AWLEN = beats-1; assert AWVALID; go to AW.
- AW:
  - AWADDR/AWLEN held stable while AWVALID && !AWREADY.
  - On handshake: AWVALID=0; WVALID=1 with the first beat's WDATA; WLAST = (beats==1); go to W.
  - W is never asserted before the AW handshake completes; only one transaction is outstanding.
- W:
  - WDATA/WLAST held stable while WVALID && !WREADY.
  - On each handshake: i++ and beat_cnt++.
  - Non-last beat: present the next word; WLAST=1 when that word is the burst's final beat.
  - Last beat: WVALID=0, WLAST=0, BREADY=1, go to B.
- B:
  - On BVALID && BREADY: BREADY=0.
  - If BRESP!=2'b00, err_cnt increments (saturating).
  - cur_addr += beats<<2, wrapping mod 2^ADDR_WIDTH; remaining -= beats.
  - remaining==0 goes to DONE; otherwise go to CALC.
- DONE: done=1 for exactly one cycle, busy=0, go to IDLE; err_cnt holds until the next start.
- Pattern:
  - mode 0: WDATA = seed.
  - mode 1: WDATA = seed + i, where i is the global word index across all bursts, and the sum wraps mod 2^DATA_WIDTH.
- Burst length is never 0 beats. A full 4KB page starting at offset 0 is split only by MAX_BURST.
- Latency:
  - start to AWVALID: 2 cycles.
  - BVALID handshake to the next AWVALID: 2 cycles.

Test Plan:
1. base 0x0000, num_words 4, mode 1, seed 0x100, always-ready slave -> one burst, AWADDR 0x0000 AWLEN 3; WDATA 0x100..0x103, WLAST on beat 4; single done pulse, err_cnt 0, busy low after done.
2. num_words 40, MAX_BURST 16 -> bursts (AWADDR/AWLEN) 0x0000/15, 0x0040/15, 0x0080/7; WDATA index continuous across bursts; memory words 0..39 hold seed+i.
3. base 0x0FF8, num_words 4 -> 4KB split into 0x0FF8/AWLEN 1 and 0x1000/AWLEN 1.
4. Same as 3 against a slave with MEMORY_DEPTH 1024 -> second burst returns BRESP 2'b10; err_cnt 1, done still asserted.
5. Backpressure: AWREADY delayed 3 cycles, WREADY toggling 1010, BVALID delayed 5 cycles -> AWADDR/AWLEN/WDATA/WLAST stable while stalled; no beat lost or duplicated; mode 0 fills every word with seed.
6. num_words 0 -> done pulse 1 cycle after start, no AWVALID. Separately, ARESETn low mid-W -> all outputs 0 within the reset, no done; a new start after reset completes normally.
